packed_rr_arbiter: RTL and testbench
====================================

Name: packed_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered output channel between P_N requesters.
- Request data arrives as a packed matrix, one P_W-bit row per requester.
- Supports burst locking: a granted requester keeps the channel until its last beat, or until P_MAX_BURST beats have passed.
- Sits in front of a shared packed/unpacked datapath sink and sequences access to it.

Parameters:
- P_N, 4, number of requesters (1..16).
- P_W, 8, data width per requester row.
- P_MAX_BURST, 4, maximum beats per grant (1..255); a value of 1 disables locking.

Ports:
- main_clk_i  input  1  clock
- main_rst_an_i  input  1  reset, synchronous, active-low
- req_valid_i  input  [P_N-1:0]  per-requester beat valid
- req_last_i  input  [P_N-1:0]  per-requester last beat of burst
- req_data_i  input  [P_N-1:0][P_W-1:0]  packed matrix, row r = requester r data
- req_ready_o  output  [P_N-1:0]  per-requester accept (one-hot or zero)
- out_valid_o  output  1  output beat valid
- out_data_o  output  [P_W-1:0]  output data
- out_id_o  output  [IDW-1:0]  requester index; IDW = max(1, clog2(P_N))
- out_last_o  output  1  last beat of the current grant
- out_ready_i  input  1  downstream accept
- busy_o  output  1  high while in LOCK state

Behaviour:
- Reset (main_rst_an_i low at a rising edge):
  - out_valid_o=0, out_data_o=0, out_id_o=0, out_last_o=0, busy_o=0.
  - Pointer ptr=0, beat count cnt=0, state IDLE.
  - req_ready_o is 0 during reset.
  - Reset mid-burst drops the captured beat and the lock. No beat is emitted in that cycle.
- Slot free: free = !out_valid_o || out_ready_i.
- Accept rule:
  - req_ready_o[g] = free && grant==g && req_valid_i[g], combinationally.
  - At most one bit of req_ready_o is set.
  - An accepted beat appears on out_* in the next cycle, so latency is 1 cycle.
  - If out_ready_i is high, back-to-back beats are accepted every cycle.
- IDLE state:
  - grant is the first r with req_valid_i[r], searching from ptr upward and wrapping at P_N-1 back to 0.
  - If no request is valid, nothing is accepted and the state stays IDLE.
  - On accept:
    - Capture data, id and last. out_last_o = req_last_i[g] || (P_MAX_BURST==1).
    - If the beat ends the grant: ptr = (g+1) mod P_N and stay IDLE.
    - Otherwise: move to LOCK with locked id L=g and cnt=1.
- LOCK state:
  - grant=L. Other requesters are ignored even when L is not valid; there is no preemption.
  - On each accept: cnt++.
  - The grant ends when req_last_i[L] is set, or when cnt+1 == P_MAX_BURST (forced last, out_last_o=1).
  - At grant end: ptr=(L+1) mod P_N, cnt=0, state IDLE.
- Output hold: while out_valid_o && !out_ready_i, out_data_o, out_id_o and out_last_o stay stable.
- If out_ready_i is high and a new accept happens in the same cycle, the output register is reloaded without a bubble.
- When out_ready_i is high and nothing is accepted, out_valid_o falls to 0.
- busy_o = (state==LOCK).
- P_N=1: ptr is always 0 and the arbiter degrades to a register slice with burst count.

Optional Feature:
- Macro: PACKED_RR_ARB_STATS_EN.
- With the macro defined:
  - Adds output port grant_cnt_o, unpacked array [P_N-1:0] of 16-bit counters (declared as [15:0] grant_cnt_o [P_N-1:0]).
  - Counter r increments at each grant end with id r.
  - Counters saturate at 16'hFFFF and reset to 0.
- Without the macro:
  - The port and counters do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset while requesters 0..3 are valid -> all outputs 0 during reset. The first cycle after release grants requester 0, and out_id_o=0 follows 1 cycle later.
- Requesters 0..3 valid, all last=1, out_ready_i=1, data rows 8'h10,8'h21,8'h32,8'h43 -> out_id_o sequence 0,1,2,3,0 with matching data, one beat per cycle.
- Requester 2 sends a 6-beat burst with last only on beat 6, P_MAX_BURST=4, requester 3 also valid -> beats 1-4 go to id 2 with out_last_o on beat 4; the next grant goes to id 3, then id 2 resumes.
- In LOCK on id 1 with req_valid_i[1]=0 for 3 cycles while 0 and 2 are valid -> req_ready_o stays 0 and busy_o=1; after id 1 sends its last beat, id 2 is granted.
- out_ready_i held low 5 cycles with a beat 8'hA5 pending -> out_data_o stays 8'hA5, no req_ready_o asserted. Releasing out_ready_i gives back-to-back transfer with no bubble.
- PACKED_RR_ARB_STATS_EN defined: 3 grants to id 0 and 1 grant to id 3 -> grant_cnt_o[0]=3, grant_cnt_o[3]=1, others 0. Preloading counter 0 at 16'hFFFE and granting id 0 twice -> 16'hFFFF.

Source files
------------

// File: rtl/packed_rr_arbiter.sv
// Round-robin arbiter with burst locking in front of one registered output channel.
// Optional per-requester grant counters are enabled with `define PACKED_RR_ARB_STATS_EN.
module packed_rr_arbiter #(
  parameter int P_N         = 4,
  parameter int P_W         = 8,
  parameter int P_MAX_BURST = 4,
  localparam int IDW        = (P_N > 1) ? $clog2(P_N) : 1
) (
  input  logic                    main_clk_i,
  input  logic                    main_rst_an_i,
  input  logic [P_N-1:0]          req_valid_i,
  input  logic [P_N-1:0]          req_last_i,
  input  logic [P_N-1:0][P_W-1:0] req_data_i,
  output logic [P_N-1:0]          req_ready_o,
  output logic                    out_valid_o,
  output logic [P_W-1:0]          out_data_o,
  output logic [IDW-1:0]          out_id_o,
  output logic                    out_last_o,
  input  logic                    out_ready_i,
  output logic                    busy_o
`ifdef PACKED_RR_ARB_STATS_EN
  ,
  output logic [15:0]             grant_cnt_o [P_N-1:0]
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, lock_id, grant, nxt_ptr;
  logic [7:0]     cnt;
  logic           free, acc, ends;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= P_N) s = s - P_N;
    return IDW'(s);
  endfunction

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge main_clk_i) begin
    if (!main_rst_an_i) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) state_nxt = ends ? IDLE : LOCK;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = ptr;
    if (state == LOCK) begin
      grant = lock_id;
    end else begin
      // Descending scan: the nearest valid requester at or after ptr is written last and wins.
      for (int k = P_N - 1; k >= 0; k--) begin
        if (req_valid_i[wrap_add(ptr, k)]) grant = wrap_add(ptr, k);
      end
    end
    free    = !out_valid_o || out_ready_i;
    acc     = main_rst_an_i && free && req_valid_i[grant];
    // cnt is 0 in IDLE, so the same term also forces last when bursts are disabled.
    ends    = req_last_i[grant] || (({1'b0, cnt} + 9'd1) == 9'(P_MAX_BURST));
    nxt_ptr = wrap_add(grant, 1);
    req_ready_o = '0;
    if (acc) req_ready_o[grant] = 1'b1;
    busy_o = (state == LOCK);
  end

  always_ff @(posedge main_clk_i) begin
    if (!main_rst_an_i) begin
      ptr         <= '0;
      lock_id     <= '0;
      cnt         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_id_o    <= '0;
      out_last_o  <= 1'b0;
    end else begin
      if (acc) begin
        out_valid_o <= 1'b1;
        out_data_o  <= req_data_i[grant];
        out_id_o    <= grant;
        out_last_o  <= ends;
        if (ends) begin
          ptr <= nxt_ptr;
          cnt <= '0;
        end else begin
          lock_id <= grant;
          cnt     <= cnt + 8'd1;
        end
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

`ifdef PACKED_RR_ARB_STATS_EN
  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like other state.
  always_ff @(posedge main_clk_i) begin
    for (int r = 0; r < P_N; r++) begin
      if (!main_rst_an_i) begin
        grant_cnt_o[r] <= '0;
      end else if (acc && ends && grant == IDW'(r) && grant_cnt_o[r] != 16'hFFFF) begin
        grant_cnt_o[r] <= grant_cnt_o[r] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_packed_rr_arbiter.sv
// Directed bench for packed_rr_arbiter (P_N=4, P_W=8, P_MAX_BURST=4).
// Grant-counter checks compile in when PACKED_RR_ARB_STATS_EN is defined.
module tb_packed_rr_arbiter;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  ready;
    logic        ov;
    logic [1:0]  id;
    logic [7:0]  od;
    logic        ol;
    logic        busy;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic [3:0]      valid, last, ready;
  logic [3:0][7:0] data;
  logic            ordy, ov, ol, busy;
  logic [7:0]      od;
  logic [1:0]      id;
`ifdef PACKED_RR_ARB_STATS_EN
  logic [15:0]     gcnt [3:0];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic after_rst = 1'b1;
  vec_t rr_tab [8];

  packed_rr_arbiter #(.P_N(4), .P_W(8), .P_MAX_BURST(4)) dut (
    .main_clk_i   (clk),
    .main_rst_an_i(rst_n),
    .req_valid_i  (valid),
    .req_last_i   (last),
    .req_data_i   (data),
    .req_ready_o  (ready),
    .out_valid_o  (ov),
    .out_data_o   (od),
    .out_id_o     (id),
    .out_last_o   (ol),
    .out_ready_i  (ordy),
    .busy_o       (busy)
`ifdef PACKED_RR_ARB_STATS_EN
    ,
    .grant_cnt_o  (gcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one row, compare outputs mid-cycle, then advance one clock.
  task automatic run_vec(input vec_t v, input string tag);
    rst_n = v.rst_n;
    valid = v.valid;
    last  = v.last;
    data  = v.data;
    ordy  = v.ordy;
    #1;
    check({tag, "/ready"}, 32'(ready), 32'(v.ready));
    check({tag, "/valid"}, 32'(ov), 32'(v.ov));
    check({tag, "/busy"},  32'(busy), 32'(v.busy));
    if (v.ov || after_rst) begin
      check({tag, "/id"},   32'(id), 32'(v.id));
      check({tag, "/data"}, 32'(od), 32'(v.od));
      check({tag, "/last"}, 32'(ol), 32'(v.ol));
    end
    after_rst = !v.rst_n;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] va, input logic [3:0] la,
                      input logic [31:0] d, input logic o, input logic [3:0] rd, input logic eov,
                      input logic [1:0] eid, input logic [7:0] eod, input logic eol, input logic eb);
    vec_t v;
    v = '{r, va, la, d, o, rd, eov, eid, eod, eol, eb};
    run_vec(v, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    last  = '0;
    ordy  = 1'b1;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    after_rst = 1'b1;
  endtask

  initial begin
    rr_tab[0] = '{1'b0, 4'hF, 4'hF, 32'h43322110, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
    rr_tab[1] = '{1'b1, 4'hF, 4'hF, 32'h43322110, 1'b1, 4'h1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0};
    rr_tab[2] = '{1'b1, 4'hF, 4'hF, 32'h43322110, 1'b1, 4'h2, 1'b1, 2'd0, 8'h10, 1'b1, 1'b0};
    rr_tab[3] = '{1'b1, 4'hF, 4'hF, 32'h43322110, 1'b1, 4'h4, 1'b1, 2'd1, 8'h21, 1'b1, 1'b0};
    rr_tab[4] = '{1'b1, 4'hF, 4'hF, 32'h43322110, 1'b1, 4'h8, 1'b1, 2'd2, 8'h32, 1'b1, 1'b0};
    rr_tab[5] = '{1'b1, 4'hF, 4'hF, 32'h43322110, 1'b1, 4'h1, 1'b1, 2'd3, 8'h43, 1'b1, 1'b0};
    rr_tab[6] = '{1'b1, 4'h0, 4'h0, 32'h43322110, 1'b1, 4'h0, 1'b1, 2'd0, 8'h10, 1'b1, 1'b0};
    rr_tab[7] = '{1'b1, 4'h0, 4'h0, 32'h43322110, 1'b1, 4'h0, 1'b0, 2'd0, 8'h10, 1'b1, 1'b0};

    rst_n = 1'b0;
    valid = 4'hF;
    last  = 4'hF;
    data  = 32'h43322110;
    ordy  = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset with all requesters valid, then plain round robin.
    for (int i = 0; i < 8; i++) run_vec(rr_tab[i], $sformatf("rr%0d", i));

    // Burst from id 2 forced to end after 4 beats, id 3 interleaves, then mid-burst reset.
    do_reset();
    step("bu_a", 1, 4'hC, 4'h8, 32'h43210000, 1, 4'h4, 0, 2'd0, 8'h00, 0, 0);
    step("bu_b", 1, 4'hC, 4'h8, 32'h43220000, 1, 4'h4, 1, 2'd2, 8'h21, 0, 1);
    step("bu_c", 1, 4'hC, 4'h8, 32'h43230000, 1, 4'h4, 1, 2'd2, 8'h22, 0, 1);
    step("bu_d", 1, 4'hC, 4'h8, 32'h43240000, 1, 4'h4, 1, 2'd2, 8'h23, 0, 1);
    step("bu_e", 1, 4'hC, 4'h8, 32'h43250000, 1, 4'h8, 1, 2'd2, 8'h24, 1, 0);
    step("bu_f", 1, 4'hC, 4'h8, 32'h43250000, 1, 4'h4, 1, 2'd3, 8'h43, 1, 0);
    step("bu_g", 1, 4'hC, 4'hC, 32'h43260000, 1, 4'h4, 1, 2'd2, 8'h25, 0, 1);
    step("bu_h", 1, 4'h4, 4'h0, 32'h43270000, 1, 4'h4, 1, 2'd2, 8'h26, 1, 0);
    step("bu_i", 0, 4'h4, 4'h0, 32'h43270000, 1, 4'h0, 1, 2'd2, 8'h27, 0, 1);
    step("bu_j", 1, 4'h0, 4'h0, 32'h43270000, 1, 4'h0, 0, 2'd0, 8'h00, 0, 0);

    // Lock on id 1 holds while id 1 idles and others request.
    do_reset();
    step("lk_a", 1, 4'h2, 4'h0, 32'h43325110, 1, 4'h2, 0, 2'd0, 8'h00, 0, 0);
    step("lk_b", 1, 4'h5, 4'h0, 32'h43325110, 1, 4'h0, 1, 2'd1, 8'h51, 0, 1);
    step("lk_c", 1, 4'h5, 4'h0, 32'h43325110, 1, 4'h0, 0, 2'd0, 8'h00, 0, 1);
    step("lk_d", 1, 4'h5, 4'h0, 32'h43325110, 1, 4'h0, 0, 2'd0, 8'h00, 0, 1);
    step("lk_e", 1, 4'h7, 4'h2, 32'h43325110, 1, 4'h2, 0, 2'd0, 8'h00, 0, 1);
    step("lk_f", 1, 4'h5, 4'h4, 32'h43325110, 1, 4'h4, 1, 2'd1, 8'h51, 1, 0);
    step("lk_g", 1, 4'h0, 4'h0, 32'h43325110, 1, 4'h0, 1, 2'd2, 8'h32, 1, 0);

    // Downstream stall for 5 cycles, then back-to-back drain.
    do_reset();
    step("bp_a", 1, 4'h1, 4'h1, 32'h00005AA5, 1, 4'h1, 0, 2'd0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("bp_hold%0d", i), 1, 4'h3, 4'h3, 32'h00005AA5, 0, 4'h0, 1, 2'd0, 8'hA5, 1, 0);
    step("bp_g", 1, 4'h3, 4'h3, 32'h00005AA5, 1, 4'h2, 1, 2'd0, 8'hA5, 1, 0);
    step("bp_h", 1, 4'h3, 4'h3, 32'h00005AA5, 1, 4'h1, 1, 2'd1, 8'h5A, 1, 0);
    step("bp_i", 1, 4'h0, 4'h0, 32'h00005AA5, 1, 4'h0, 1, 2'd0, 8'hA5, 1, 0);
    step("bp_j", 1, 4'h0, 4'h0, 32'h00005AA5, 1, 4'h0, 0, 2'd0, 8'h00, 0, 0);

`ifdef PACKED_RR_ARB_STATS_EN
    do_reset();
    valid = 4'h1;
    last  = 4'h1;
    repeat (3) @(posedge clk);
    #1;
    valid = 4'h8;
    last  = 4'h8;
    @(posedge clk);
    #1;
    valid = 4'h0;
    @(posedge clk);
    #1;
    check("gcnt0", 32'(gcnt[0]), 32'd3);
    check("gcnt1", 32'(gcnt[1]), 32'd0);
    check("gcnt2", 32'(gcnt[2]), 32'd0);
    check("gcnt3", 32'(gcnt[3]), 32'd1);

    do_reset();
    valid = 4'h1;
    last  = 4'h1;
    repeat (65534) @(posedge clk);
    #1;
    check("gcnt0_fffe", 32'(gcnt[0]), 32'h0000FFFE);
    repeat (2) @(posedge clk);
    #1;
    check("gcnt0_sat", 32'(gcnt[0]), 32'h0000FFFF);
    @(posedge clk);
    #1;
    check("gcnt0_hold", 32'(gcnt[0]), 32'h0000FFFF);
    valid = 4'h0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
